// File: rtl/mountaincar_step_check.sv
// MountainCar step result stage: left-wall velocity reset, reward, goal/step-limit
// detection and episode step counting, registered with one cycle of latency.
module mountaincar_step_check #(
  parameter int VEL_WL    = 32,
  parameter int POS_WL    = 32,
  parameter int STEP_WL   = 8,
  parameter int MAX_STEPS = 200
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_episode_start,
  input  logic               i_pos_valid,
  input  logic [POS_WL-1:0]  i_pos,
  input  logic [VEL_WL-1:0]  i_vel,
  output logic               o_valid,
  output logic [POS_WL-1:0]  o_pos,
  output logic [VEL_WL-1:0]  o_vel,
  output logic [31:0]        o_reward,
  output logic               o_terminated,
  output logic               o_truncated,
  output logic               o_done,
  output logic [STEP_WL-1:0] o_step_cnt,
  output logic               o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0]        REWARD_NEG_ONE = 32'hbf800000;
  localparam logic [30:0]        POS_LEFT_MAG   = 31'h3f99999a;  // |-1.2|
  localparam logic [30:0]        POS_GOAL_MAG   = 31'h3f000000;  // 0.5
  localparam logic [STEP_WL-1:0] STEP_LIMIT     = STEP_WL'(MAX_STEPS);

  logic [1:0]         state_reg, state_next;
  logic [STEP_WL-1:0] step_cnt_reg, step_cnt_next;
  logic [STEP_WL-1:0] cnt_base, cnt_new;
  logic               accept, vel_neg, at_left, goal, trunc, done_now;

  // A start in the same cycle as a sample is applied first, so the sample is step 1.
  assign accept   = i_pos_valid && ((state_reg == ST_RUN) || i_episode_start);
  assign cnt_base = i_episode_start ? '0 : step_cnt_reg;
  assign cnt_new  = cnt_base + STEP_WL'(1);

  // Sign/magnitude compares; -0.0 never counts as a negative velocity.
  assign vel_neg  = i_vel[VEL_WL-1] && (i_vel[VEL_WL-2:0] != '0);
  assign at_left  = i_pos[POS_WL-1] && (i_pos[POS_WL-2:0] >= POS_LEFT_MAG);
  assign goal     = !i_pos[POS_WL-1] && (i_pos[POS_WL-2:0] >= POS_GOAL_MAG) && !vel_neg;
  assign trunc    = (cnt_new == STEP_LIMIT);
  assign done_now = goal || trunc;

  always_comb begin
    state_next    = state_reg;
    step_cnt_next = step_cnt_reg;
    if (i_episode_start) begin
      state_next    = ST_RUN;
      step_cnt_next = '0;
    end
    if (accept) begin
      step_cnt_next = cnt_new;
      if (done_now) state_next = ST_DONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      step_cnt_reg <= '0;
      o_valid      <= 1'b0;
      o_pos        <= '0;
      o_vel        <= '0;
      o_reward     <= '0;
      o_terminated <= 1'b0;
      o_truncated  <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      step_cnt_reg <= step_cnt_next;
      o_valid      <= accept;
      o_terminated <= accept && goal;
      o_truncated  <= accept && trunc;
      o_done       <= accept && done_now;
      if (accept) begin
        o_pos    <= i_pos;
        o_vel    <= (at_left && vel_neg) ? '0 : i_vel;
        o_reward <= REWARD_NEG_ONE;
      end
    end
  end

  assign o_step_cnt = step_cnt_reg;
  assign o_busy     = (state_reg == ST_RUN);

endmodule

// File: doc/mountaincar_step_check.md
# mountaincar_step_check

Downstream stage of the MountainCar position computation. Each cycle it can take one clipped position and the velocity that produced it. It applies the left-wall velocity reset, assigns the per-step reward, detects goal termination and step-limit truncation, and tracks the episode step count. Its registered outputs form the environment step result returned to the agent interface.

## Interface
Parameters:
- VEL_WL, 32, velocity width (IEEE-754 single)
- POS_WL, 32, position width (IEEE-754 single)
- STEP_WL, 8, step counter width
- MAX_STEPS, 200, episode step limit (1..2^STEP_WL-1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_episode_start  in  1  one-cycle pulse that starts a new episode
- i_pos_valid  in  1  i_pos/i_vel valid this cycle
- i_pos  in  POS_WL  clipped position from the position stage
- i_vel  in  VEL_WL  velocity used to compute i_pos
- o_valid  out  1  step result valid (one-cycle pulse)
- o_pos  out  POS_WL  position, passed through
- o_vel  out  VEL_WL  velocity after the left-wall rule
- o_reward  out  32  reward, always 32'hbf800000 (-1.0) when o_valid
- o_terminated  out  1  goal reached
- o_truncated  out  1  step limit reached
- o_done  out  1  o_terminated | o_truncated
- o_step_cnt  out  STEP_WL  steps taken in the episode, including this one
- o_busy  out  1  high in the RUN state

## Operation
- States:
  - IDLE: after reset, no episode.
  - RUN: episode active.
  - DONE: episode ended; waits for the next start.
- Transitions:
  - i_episode_start from any state -> RUN and step counter := 0.
  - In RUN, an accepted sample with the done condition -> DONE.
- Acceptance:
  - A sample is accepted when i_pos_valid=1 and either the state is RUN, or i_episode_start=1 in the same cycle.
  - When start and valid coincide, the start is applied first. The sample becomes step 1 of the new episode.
  - i_pos_valid in IDLE or DONE without a start is ignored: no o_valid, no state change.
- Float decisions use bit-level sign/magnitude compares; there is no FP core.
  - vel_neg: i_vel[31]=1 and i_vel[30:0]!=0. -0.0 is not negative.
  - at_left: i_pos[31]=1 and i_pos[30:0] >= 31'h3f99999a (pos <= -1.2).
  - goal: i_pos[31]=0 and i_pos[30:0] >= 31'h3f000000 (pos >= 0.5), and vel_neg=0.
- o_vel rule: 32'h00000000 if at_left && vel_neg; otherwise i_vel unchanged.
- Step counter increments on each accepted sample. truncated = (new count == MAX_STEPS).
- Terminated and truncated can both assert on the same step; both flags are then set.
- o_step_cnt holds its value between valids.
- o_terminated, o_truncated and o_done are valid only with o_valid; they are 0 otherwise.

## Timing
- Latency is 1 cycle: an accepted sample at edge N produces o_valid=1 at edge N+1 with all result fields.
- Throughput is one sample per cycle. There is no backpressure, so the upstream must not need stalls.
- Reset values:
  - o_valid, o_terminated, o_truncated, o_done, o_busy = 0.
  - o_pos, o_vel, o_reward = 0.
  - o_step_cnt = 0; state = IDLE.
- i_rst has priority over all inputs.
  - Reset mid-episode drops any sample in that cycle.
  - The next cycle shows reset values.
- i_episode_start alone (no valid):
  - o_step_cnt reads 0 the next cycle.
  - o_busy reads 1 the next cycle.
  - o_valid stays 0.
- A done step moves the state to DONE on the same edge that registers o_valid/o_done. o_busy drops with that edge.
- o_pos, o_vel and o_reward update only on accepted samples and hold otherwise.

## Test plan
- Start, then feed pos=32'hbf000000 (-0.5), vel=32'h3c23d70a (0.01) for 3 cycles -> three o_valid pulses; o_step_cnt=1,2,3; o_vel unchanged; reward bf800000; o_done=0.
- In RUN, pos=32'hbf99999a, vel=32'hbd8f5c29 (-0.07) -> o_vel=0; pos passed through; o_done=0. Repeat with vel=32'h80000000 -> o_vel=32'h80000000.
- pos=32'h3f000000, vel=0 -> o_terminated=1, o_done=1, o_busy=0 next cycle. A following valid without start -> no o_valid.
- Run MAX_STEPS=200 non-goal samples -> step 200 gives o_truncated=1, o_step_cnt=200. A goal on step 200 gives o_terminated=o_truncated=1.
- i_episode_start with i_pos_valid in DONE -> o_step_cnt=1, o_valid=1, state RUN.
- Assert i_rst at step 50 with a valid sample present -> next cycle all outputs 0, IDLE; valid samples ignored until a start.
